// File: rtl/param_register_file.sv
// Dual-write, dual-read register file with a DEPTH-cycle clear sweep (also entered on reset).
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module param_register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [ADDR_W-1:0] rw2,
    input  logic              we1,
    input  logic              we2,
    input  logic [DATA_W-1:0] busw1,
    input  logic [DATA_W-1:0] busw2,
    input  logic              clear,
    output logic [DATA_W-1:0] busa,
    output logic [DATA_W-1:0] busb,
    output logic              busy,
    output logic              collision
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     w_cnt_nx;
    logic                r_busy;
    logic                r_collision;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr1_ok;
    logic                w_wr2_ok;
    logic                w_coll_nx;
    logic [DATA_W-1:0]   w_busa;
    logic [DATA_W-1:0]   w_busb;

    // Qualify writes: only in IDLE, and never into a hard-wired zero register.
    always_comb begin
        w_wr1_ok  = (r_state == IDLE) && we1 && !((ZERO_REG != 0) && (rw1 == ZERO_ADDR));
        w_wr2_ok  = (r_state == IDLE) && we2 && !((ZERO_REG != 0) && (rw2 == ZERO_ADDR));
        // Collision is about the two ports aiming at one address, even if that address is 0.
        w_coll_nx = (r_state == IDLE) && we1 && we2 && (rw1 == rw2);
    end

    // Next-state and sweep-counter logic.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_state_nx = SWEEP;
                    w_cnt_nx   = '0;
                end else begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = r_cnt;
                end
            end
            SWEEP: begin
                // Counter is one bit wider than the address, and the last index exits, so it never wraps.
                if (r_cnt == LAST_IDX) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_state_nx = SWEEP;
                    w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State, counter and status registers; reset forces a fresh sweep from index 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= SWEEP;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_busy      <= (w_state_nx == SWEEP);
            r_collision <= w_coll_nx;
        end
    end

    // Storage array: sweep zeroes one entry per cycle; in IDLE port 1 is written last so it wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == SWEEP) begin
                r_mem[r_cnt[ADDR_W-1:0]] <= '0;
            end else begin
                if (w_wr2_ok) begin
                    r_mem[rw2] <= busw2;
                end
                if (w_wr1_ok) begin
                    r_mem[rw1] <= busw1;
                end
            end
        end
    end

    // Read port A.
    always_comb begin
        w_busa = '0;
        if (r_state == SWEEP) begin
            w_busa = '0;
        end else if ((ZERO_REG != 0) && (ra == ZERO_ADDR)) begin
            w_busa = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (w_wr1_ok && (rw1 == ra)) begin
            w_busa = busw1;
        end else if (w_wr2_ok && (rw2 == ra)) begin
            w_busa = busw2;
`endif
        end else begin
            w_busa = r_mem[ra];
        end
    end

    // Read port B.
    always_comb begin
        w_busb = '0;
        if (r_state == SWEEP) begin
            w_busb = '0;
        end else if ((ZERO_REG != 0) && (rb == ZERO_ADDR)) begin
            w_busb = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (w_wr1_ok && (rw1 == rb)) begin
            w_busb = busw1;
        end else if (w_wr2_ok && (rw2 == rb)) begin
            w_busb = busw2;
`endif
        end else begin
            w_busb = r_mem[rb];
        end
    end

    assign busa      = w_busa;
    assign busb      = w_busb;
    assign busy      = r_busy;
    assign collision = r_collision;

endmodule

// File: tb/tb_param_register_file.sv
// Randomized + directed bench for param_register_file (default parameters), checked against
// an array-based reference model; honours REGFILE_BYPASS_EN when the bundle is built with it.
module tb_param_register_file;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  ra, rb, rw1, rw2;
    logic        we1, we2, clear;
    logic [15:0] busw1, busw2;
    logic [15:0] busa, busb;
    logic        busy, collision;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: register contents, remaining sweep cycles, expected collision.
    logic [15:0] model [8];
    int          sweep_left = 0;
    logic        coll_exp   = 1'b0;
    bit          model_valid = 1'b0;
    logic        s_busy;
    logic [15:0] s_busa;

    param_register_file dut (
        .clock     (clock),
        .reset     (reset),
        .ra        (ra),
        .rb        (rb),
        .rw1       (rw1),
        .rw2       (rw2),
        .we1       (we1),
        .we2       (we2),
        .busw1     (busw1),
        .busw2     (busw2),
        .clear     (clear),
        .busa      (busa),
        .busb      (busb),
        .busy      (busy),
        .collision (collision)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] a);
        if (sweep_left > 0) return 16'd0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && rw1 == a) return busw1;
        if (we2 && rw2 == a) return busw2;
`endif
        return model[a];
    endfunction

    // Apply model rules for the rising edge with the currently driven inputs.
    task automatic model_edge();
        if (reset) begin
            sweep_left  = 8;
            coll_exp    = 1'b0;
            model_valid = 1'b1;
        end else if (sweep_left > 0) begin
            model[8 - sweep_left] = 16'd0;
            sweep_left--;
            coll_exp = 1'b0;
        end else begin
            if (we2) model[rw2] = busw2;
            if (we1) model[rw1] = busw1;
            coll_exp = we1 && we2 && (rw1 == rw2);
            if (clear) sweep_left = 8;
        end
    endtask

    // One clock: check outputs mid-cycle, take the edge, update model, return at negedge.
    task automatic step();
        #1;
        s_busy = busy;
        s_busa = busa;
        if (model_valid) begin
            check_eq("busa", busa, exp_read(ra));
            check_eq("busb", busb, exp_read(rb));
            check_eq("busy", busy, (sweep_left > 0) ? 1 : 0);
            check_eq("collision", collision, coll_exp);
        end
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_busy) begin
                n++;
                check_eq("sweep_busa_zero", s_busa, 0);
            end else begin
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; clear = 1'b0;
        we1 = 1'b0; we2 = 1'b0;
        rw1 = 3'd0; rw2 = 3'd0; busw1 = 16'd0; busw2 = 16'd0;
        ra = 3'd0; rb = 3'd0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) model[i] = 16'd0;
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        step();
        reset = 1'b0;

        // Reset: 8 busy cycles, then everything reads zero
        count_busy(n);
        check_eq("reset_busy_len", n, 8);
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(7 - i);
            #1;
            check_eq("rst_busa", busa, 0);
            check_eq("rst_busb", busb, 0);
            step();
        end

        // Dual write to distinct addresses
        we1 = 1'b1; rw1 = 3'd1; busw1 = 16'd8;
        we2 = 1'b1; rw2 = 3'd2; busw2 = 16'd16;
        step();
        we1 = 1'b0; we2 = 1'b0; ra = 3'd2; rb = 3'd1;
        #1;
        check_eq("dual_busa", busa, 16);
        check_eq("dual_busb", busb, 8);
        check_eq("dual_coll", collision, 0);
        step();

        // Collision: port 1 wins, one-cycle pulse
        we1 = 1'b1; we2 = 1'b1; rw1 = 3'd2; rw2 = 3'd2; busw1 = 16'd32; busw2 = 16'd64;
        step();
        we1 = 1'b0; we2 = 1'b0; ra = 3'd2;
        #1;
        check_eq("coll_data", busa, 32);
        check_eq("coll_pulse", collision, 1);
        step();
        #1;
        check_eq("coll_drop", collision, 0);
        step();

        // Disabled write leaves reg2 alone
        rw1 = 3'd2; busw1 = 16'd64; we1 = 1'b0;
        step();
        ra = 3'd2;
        #1;
        check_eq("nowrite_reg2", busa, 32);
        step();

        // Same-cycle bypass (or pre-edge value without it)
        we1 = 1'b1; rw1 = 3'd4; busw1 = 16'd77; ra = 3'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("bypass_same", busa, 77);
`else
        check_eq("bypass_old", busa, 0);
`endif
        step();
        we1 = 1'b0;
        #1;
        check_eq("bypass_next", busa, 77);
        step();

        // Clear sweep with an ignored write in flight
        we1 = 1'b1; rw1 = 3'd3; busw1 = 16'd5;
        step();
        we1 = 1'b0; clear = 1'b1; ra = 3'd3;
        #1;
        check_eq("preclear_reg3", busa, 5);
        step();
        clear = 1'b0;
        we1 = 1'b1; rw1 = 3'd3; busw1 = 16'd9;
        step();
        check_eq("clear_busy_first", s_busy, 1);
        we1 = 1'b0;
        count_busy(n);
        check_eq("clear_len", n + 1, 8);
        #1;
        check_eq("clear_reg3", busa, 0);
        step();

        // Reset at sweep cycle 4 restarts a full sweep
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(n);
        check_eq("restart_len", n, 8);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            ra    = 3'($urandom_range(0, 7));
            rb    = 3'($urandom_range(0, 7));
            we1   = 1'($urandom_range(0, 1));
            we2   = 1'($urandom_range(0, 1));
            rw1   = 3'($urandom_range(0, 7));
            rw2   = ($urandom_range(0, 3) == 0) ? rw1 : 3'($urandom_range(0, 7));
            busw1 = 16'($urandom_range(0, 65535));
            busw2 = 16'($urandom_range(0, 65535));
            clear = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        idle_inputs();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
